// File: rtl/out_trace_pkg.sv
// out_trace_pkg: shared defaults and entry layout for the output trace buffer.
// Optional OUT_TRACE_TIMESTAMP_EN adds a cycle stamp field to each entry.
package out_trace_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int DW_DEF = 32;
  localparam int DROP_W = 8;
  localparam int STAMP_W = 16;
  typedef struct packed {
`ifdef OUT_TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0] stamp;
`endif
    logic [DW_DEF-1:0] data;
  } entry_t;
endpackage

// File: rtl/out_trace_buffer_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with occupancy count, zero head when empty.
// Ports: clk, rst (sync active-low), push/pop requests, wr_data in, rd_data/count/full/empty out.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  // A write into a full FIFO is legal when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/out_trace_buffer.sv
// out_trace_buffer: captures changes of the processor result bus into a FIFO with overflow tracking.
// Ports: clk, rst (sync active-low), out_top, cap_en, rd_valid/rd_ready/rd_data, count, ovf,
// drop_cnt, clr_ovf; rd_stamp only when OUT_TRACE_TIMESTAMP_EN is defined.
module out_trace_buffer
  import out_trace_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            out_top,
  input  logic                     cap_en,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clr_ovf
`ifdef OUT_TRACE_TIMESTAMP_EN
  ,
  output logic [STAMP_W-1:0]       rd_stamp
`endif
);
  logic [DW-1:0] prev;
  logic prev_vld, full, empty, pop, cap, drop;
  assign pop = rd_valid & rd_ready;
  assign cap = cap_en & (~prev_vld | (out_top != prev));
  assign drop = cap & full & ~pop;
  assign rd_valid = ~empty;
`ifdef OUT_TRACE_TIMESTAMP_EN
  logic [STAMP_W-1:0] stamp;
  logic [STAMP_W+DW-1:0] head;
  always_ff @(posedge clk) stamp <= !rst ? '0 : stamp + 1'b1;
  sync_fifo #(.DEPTH(DEPTH), .W(STAMP_W+DW)) u_fifo (
    .clk(clk), .rst(rst), .push(cap), .pop(pop), .wr_data({stamp, out_top}),
    .rd_data(head), .count(count), .full(full), .empty(empty)
  );
  assign rd_data = head[DW-1:0];
  assign rd_stamp = head[DW+:STAMP_W];
`else
  sync_fifo #(.DEPTH(DEPTH), .W(DW)) u_fifo (
    .clk(clk), .rst(rst), .push(cap), .pop(pop), .wr_data(out_top),
    .rd_data(rd_data), .count(count), .full(full), .empty(empty)
  );
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev <= '0;
      prev_vld <= 1'b0;
      ovf <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (cap) begin
        prev <= out_top;
        prev_vld <= 1'b1;
      end
      // A drop outranks a coincident clear, restarting the tally at one.
      ovf <= drop | (ovf & ~clr_ovf);
      drop_cnt <= drop ? (clr_ovf ? DROP_W'(1) : drop_cnt + DROP_W'(drop_cnt != '1)) :
                  clr_ovf ? '0 : drop_cnt;
    end
  end
endmodule

// File: tb/tb_out_trace_buffer.sv
// tb_out_trace_buffer: directed scoreboard bench for out_trace_buffer.
module tb_out_trace_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] out_top = '0;
  logic cap_en = 1'b0;
  logic rd_valid;
  logic rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic [3:0] count;
  logic ovf;
  logic [7:0] drop_cnt;
  logic clr_ovf = 1'b0;
`ifdef OUT_TRACE_TIMESTAMP_EN
  logic [15:0] rd_stamp;
`endif
  int passed = 0;
  int total = 0;
  logic [31:0] exp_q[$];

  out_trace_buffer #(.DEPTH(8), .DW(32)) dut (
    .clk(clk), .rst(rst), .out_top(out_top), .cap_en(cap_en), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .count(count), .ovf(ovf),
    .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
`ifdef OUT_TRACE_TIMESTAMP_EN
    , .rd_stamp(rd_stamp)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: each accepted head entry is compared against the scoreboard queue.
  always @(negedge clk) begin
    if (rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) chk("unexpected_entry", rd_data, 32'hDEAD_BEEF);
      else chk("rd_data", rd_data, exp_q.pop_front());
    end else if (!rd_valid) begin
      chk("rd_data_idle_zero", rd_data, 0);
    end
  end

  initial begin
    tick(2);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    rst = 1'b1;
    tick(1);
    // Held value produces exactly one entry.
    cap_en = 1'b1;
    out_top = 5;
    exp_q.push_back(5);
    tick(1);
    chk("hold_valid_1cyc", 32'(rd_valid), 1);
    chk("hold_count_1cyc", 32'(count), 1);
    tick(3);
    chk("hold_count", 32'(count), 1);
    rd_ready = 1'b1;
    tick(1);
    cap_en = 1'b0;
    rd_ready = 1'b0;
    chk("hold_drained", 32'(count), 0);
    // Change detection with a streaming consumer.
    rd_ready = 1'b1;
    cap_en = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    foreach (exp_q[i]) ;
    out_top = 1; tick(1);
    out_top = 2; tick(1);
    out_top = 2; tick(1);
    out_top = 3; tick(1);
    cap_en = 1'b0;
    tick(3);
    chk("seq_valid_low", 32'(rd_valid), 0);
    chk("seq_data_zero", rd_data, 0);
    chk("seq_queue_empty", 32'(exp_q.size()), 0);
    // Overflow: 10 distinct values into 8 slots.
    rd_ready = 1'b0;
    cap_en = 1'b1;
    for (int v = 10; v < 20; v++) begin
      out_top = 32'(v);
      if (v < 18) exp_q.push_back(32'(v));
      tick(1);
    end
    cap_en = 1'b0;
    chk("ovf_count", 32'(count), 8);
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_drop", 32'(drop_cnt), 2);
    // Full with a simultaneous pop still stores the new value.
    cap_en = 1'b1;
    rd_ready = 1'b1;
    out_top = 20;
    exp_q.push_back(20);
    tick(1);
    cap_en = 1'b0;
    rd_ready = 1'b0;
    chk("fullpop_count", 32'(count), 8);
    chk("fullpop_ovf", 32'(ovf), 1);
    chk("fullpop_drop", 32'(drop_cnt), 2);
    // Drop beats a coincident clear; a lone clear then zeroes both.
    cap_en = 1'b1;
    out_top = 21;
    clr_ovf = 1'b1;
    tick(1);
    cap_en = 1'b0;
    chk("clrdrop_ovf", 32'(ovf), 1);
    chk("clrdrop_cnt", 32'(drop_cnt), 1);
    tick(1);
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_cnt", 32'(drop_cnt), 0);
    rd_ready = 1'b1;
    tick(8);
    chk("drain_count", 32'(count), 0);
    chk("drain_queue", 32'(exp_q.size()), 0);
    // rd_ready while empty must not move anything.
    tick(3);
    rd_ready = 1'b0;
    chk("empty_ready_count", 32'(count), 0);
    chk("empty_ready_valid", 32'(rd_valid), 0);
    // Mid-operation reset discards entries; unchanged input is recaptured.
    cap_en = 1'b1;
    out_top = 30; tick(1);
    out_top = 31; tick(1);
    out_top = 32; tick(1);
    chk("pre_rst_count", 32'(count), 3);
    rst = 1'b0;
    tick(2);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(rd_valid), 0);
    rst = 1'b1;
    exp_q.push_back(32);
    tick(1);
    chk("post_rst_count", 32'(count), 1);
    tick(2);
    chk("post_rst_nodup", 32'(count), 1);
    cap_en = 1'b0;
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    chk("final_count", 32'(count), 0);
    chk("final_queue", 32'(exp_q.size()), 0);
    tick(1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/out_trace_buffer.md
OUT_TRACE_BUFFER -- requirements
Module: out_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter DW, default 32, traced data width; equals processor out_top width.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk, input, 1, rising-edge clock shared with the processor top.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port out_top, input, DW, processor result bus to be traced.
REQ-007 SHALL have port cap_en, input, 1, capture enable.
REQ-008 SHALL have port rd_valid, output, 1, head entry available.
REQ-009 SHALL have port rd_ready, input, 1, consumer accepts head entry.
REQ-010 SHALL have port rd_data, output, DW, head entry value.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1, current occupancy.
REQ-012 SHALL have port ovf, output, 1, sticky overflow flag.
REQ-013 SHALL have port drop_cnt, output, 8, saturating count of dropped samples.
REQ-014 SHALL have port clr_ovf, input, 1, clears ovf and drop_cnt.

Function
REQ-015 SHALL raise a capture event on a clk edge when cap_en=1 and either no previous sample is held or out_top differs from the held previous sample.
REQ-016 SHALL update the held previous sample to out_top on every capture event, whether the entry is stored or dropped.
REQ-017 SHALL write the entry on a capture event when not full, or when full and a pop occurs on the same edge.
REQ-018 SHALL assert rd_valid on the cycle after the entry is written into an empty FIFO; latency is 1 cycle.
REQ-019 SHALL pop on an edge where rd_valid=1 and rd_ready=1, and hold rd_data stable while rd_valid=1 and rd_ready=0.
REQ-020 SHALL drive rd_data=0 whenever rd_valid=0.
REQ-021 SHALL ignore rd_ready while the FIFO is empty, with no pointer movement.
REQ-022 SHALL wrap read and write pointers modulo DEPTH.
REQ-023 SHALL keep count unchanged when push and pop occur on the same edge.
REQ-024 SHALL drop a capture event when full without a pop, set ovf, and increment drop_cnt saturating at 255.
REQ-025 SHALL make a drop win over clr_ovf on the same edge, leaving ovf=1 and drop_cnt=1.
REQ-026 SHALL preserve FIFO contents and the held previous sample while cap_en=0.

Reset
REQ-027 SHALL, when rst=0 at a clk edge, set rd_valid=0, rd_data=0, count=0, ovf=0, drop_cnt=0, both pointers=0, and mark the previous sample invalid.
REQ-028 SHALL discard all stored entries on a reset mid-operation; the first capture after reset is always stored.

Configuration
REQ-029 SHALL, with OUT_TRACE_TIMESTAMP_EN defined, add a 16-bit free-running cycle counter, reset to 0 and wrapping, store the counter value with each entry, and expose it on output rd_stamp (16 bits, 0 when rd_valid=0).
REQ-030 SHALL, without OUT_TRACE_TIMESTAMP_EN, omit the counter, the rd_stamp port, and the stamp storage.

Structure
REQ-031 SHALL place in package out_trace_pkg: the default DEPTH, DW, the drop-counter width, the stamp width, and the entry struct (data plus optional stamp).
REQ-032 SHALL implement storage and pointers in one sub-module sync_fifo; change detection, overflow, and stamping stay in out_trace_buffer.

Verification
REQ-033 SHALL cover: reset, cap_en=1, out_top=5 held for 4 cycles -> exactly one entry 5, rd_valid high one cycle later, count=1.
REQ-034 SHALL cover: out_top sequence 1,2,2,3 with rd_ready=1 -> rd_data sequence 1,2,3, then rd_valid=0 and rd_data=0.
REQ-035 SHALL cover: rd_ready=0, 10 distinct values with DEPTH=8 -> count=8, ovf=1, drop_cnt=2, and the first 8 values drained in order.
REQ-036 SHALL cover: full FIFO, new distinct value with pop on the same edge -> value stored, count stays 8, ovf unchanged.
REQ-037 SHALL cover: clr_ovf coincident with a drop -> ovf=1, drop_cnt=1; clr_ovf alone next cycle -> ovf=0, drop_cnt=0.
REQ-038 SHALL cover: rst=0 with 3 entries queued, then release with out_top unchanged -> FIFO empty, then one entry of the unchanged value is captured.
